// File: rtl/spike_mon_pkg.sv
// Shared widths, summary record and output FSM encoding for the spike rate monitor.
package spike_mon_pkg;

    localparam int unsigned MEM_W           = 8;
    localparam int unsigned DEF_WINDOW_LOG2 = 8;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_ISI_W       = 8;

    // One window summary at the default widths.
    typedef struct packed {
        logic [DEF_CNT_W-1:0] count;
        logic [DEF_ISI_W-1:0] min_isi;
        logic [DEF_ISI_W-1:0] last_isi;
        logic [MEM_W-1:0]     peak;
    } summary_t;

    typedef enum logic [0:0] {EMPTY, FULL} out_state_e;

endpackage

// File: rtl/isi_tracker.sv
// Spike rising-edge detection and inter-spike interval measurement.
// The interval timer runs across window boundaries.
module isi_tracker
    import spike_mon_pkg::*;
#(
    parameter int unsigned ISI_W = DEF_ISI_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ena_i,
    input  logic             spike_i,
    output logic             event_o,
    output logic             isi_valid_o,
    output logic [ISI_W-1:0] isi_o,
    output logic [ISI_W-1:0] last_isi_d_o
);

    localparam logic [ISI_W-1:0] IsiMax = '1;

    logic             spike_q;
    logic             seen_first_q;
    logic [ISI_W-1:0] timer_q;
    logic [ISI_W-1:0] last_isi_q;

    // Event strobe, saturated interval and next value of the most recent interval.
    always_comb begin
        event_o      = ena_i && spike_i && !spike_q;
        isi_o        = (timer_q == IsiMax) ? IsiMax : timer_q + 1'b1;
        isi_valid_o  = event_o && seen_first_q;
        last_isi_d_o = isi_valid_o ? isi_o : last_isi_q;
    end

    // Edge history, saturating interval timer and last-interval register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spike_q      <= 1'b0;
            seen_first_q <= 1'b0;
            timer_q      <= '0;
            last_isi_q   <= '0;
        end else if (ena_i) begin
            spike_q    <= spike_i;
            last_isi_q <= last_isi_d_o;
            if (event_o) begin
                timer_q      <= '0;
                seen_first_q <= 1'b1;
            end else if (timer_q != IsiMax) begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_rate_monitor.sv
// Reduces fixed windows of neuron activity to summary records on a valid/ready port.
module spike_rate_monitor
    import spike_mon_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2 = DEF_WINDOW_LOG2,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned ISI_W       = DEF_ISI_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             spike,
    input  logic [MEM_W-1:0] state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [ISI_W-1:0] out_min_isi,
    output logic [ISI_W-1:0] out_last_isi,
    output logic [MEM_W-1:0] out_peak,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [ISI_W-1:0] IsiMax = '1;

    logic                   ev;
    logic                   isi_valid;
    logic [ISI_W-1:0]       isi;
    logic [ISI_W-1:0]       last_isi_d;

    logic [WINDOW_LOG2-1:0] win_cnt_q;
    logic [CNT_W-1:0]       acc_count_q, acc_count_d;
    logic [ISI_W-1:0]       acc_min_q, acc_min_d;
    logic [MEM_W-1:0]       acc_peak_q, acc_peak_d;
    logic                   close;
    out_state_e             out_state_q;

    isi_tracker #(
        .ISI_W (ISI_W)
    ) u_isi_tracker (
        .clk_i        (clk),
        .rst_i        (rst),
        .ena_i        (ena),
        .spike_i      (spike),
        .event_o      (ev),
        .isi_valid_o  (isi_valid),
        .isi_o        (isi),
        .last_isi_d_o (last_isi_d)
    );

    // Accumulator next values including this cycle's contribution.
    always_comb begin
        close       = ena && (win_cnt_q == '1);
        acc_count_d = (ev && (acc_count_q != CntMax)) ? acc_count_q + 1'b1 : acc_count_q;
        acc_min_d   = (isi_valid && (isi < acc_min_q)) ? isi : acc_min_q;
        acc_peak_d  = (state > acc_peak_q) ? state : acc_peak_q;
    end

    // Window position and per-window accumulators; cleared after each close.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_q   <= '0;
            acc_count_q <= '0;
            acc_min_q   <= IsiMax;
            acc_peak_q  <= '0;
        end else if (ena) begin
            win_cnt_q <= win_cnt_q + 1'b1;
            if (close) begin
                acc_count_q <= '0;
                acc_min_q   <= IsiMax;
                acc_peak_q  <= '0;
            end else begin
                acc_count_q <= acc_count_d;
                acc_min_q   <= acc_min_d;
                acc_peak_q  <= acc_peak_d;
            end
        end
    end

    // Output record holding FSM; a close while unaccepted overwrites and flags overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_state_q  <= EMPTY;
            out_valid    <= 1'b0;
            out_count    <= '0;
            out_min_isi  <= IsiMax;
            out_last_isi <= '0;
            out_peak     <= '0;
            overrun      <= 1'b0;
        end else begin
            if (close) begin
                out_count    <= acc_count_d;
                out_min_isi  <= acc_min_d;
                out_last_isi <= last_isi_d;
                out_peak     <= acc_peak_d;
                out_state_q  <= FULL;
                out_valid    <= 1'b1;
                if ((out_state_q == FULL) && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if ((out_state_q == FULL) && out_ready) begin
                out_state_q <= EMPTY;
                out_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Self-checking bench for spike_rate_monitor with 16-cycle windows.
module tb_spike_rate_monitor;

    localparam int WIN = 16;

    logic       clk = 1'b0;
    logic       rst, ena, spike, out_ready;
    logic [7:0] state;
    logic       out_valid, overrun;
    logic [7:0] out_count, out_min_isi, out_last_isi, out_peak;

    int total = 0;
    int bad   = 0;

    // Reference model state: absolute enabled-cycle times and per-window event lists.
    int ecycle, pos, last_t, win_count, win_peak, last_isi_m;
    bit have_last, prev_spike;
    int win_isis[$];
    bit exp_valid, exp_overrun;
    int exp_count, exp_min, exp_last, exp_peak;

    spike_rate_monitor #(
        .WINDOW_LOG2 (4),
        .CNT_W       (8),
        .ISI_W       (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .spike        (spike),
        .state        (state),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_count    (out_count),
        .out_min_isi  (out_min_isi),
        .out_last_isi (out_last_isi),
        .out_peak     (out_peak),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear_window();
        win_count = 0;
        win_peak  = 0;
        win_isis.delete();
    endtask

    // Advances the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit accept;
        int mn;
        if (rst) begin
            ecycle = 0; pos = 0; last_t = 0; have_last = 0; prev_spike = 0;
            last_isi_m = 0;
            model_clear_window();
            exp_valid = 0; exp_overrun = 0;
            exp_count = 0; exp_min = 255; exp_last = 0; exp_peak = 0;
            return;
        end
        accept = exp_valid && out_ready;
        if (ena) begin
            if (spike && !prev_spike) begin
                if (have_last) begin
                    last_isi_m = (ecycle - last_t > 255) ? 255 : ecycle - last_t;
                    win_isis.push_back(last_isi_m);
                end
                last_t    = ecycle;
                have_last = 1;
                win_count++;
            end
            prev_spike = spike;
            if (int'(state) > win_peak) win_peak = int'(state);
            ecycle++;
            pos++;
        end
        if (ena && pos == WIN) begin
            mn = 255;
            foreach (win_isis[i]) if (win_isis[i] < mn) mn = win_isis[i];
            if (exp_valid && !out_ready) exp_overrun = 1;
            exp_valid = 1;
            exp_count = (win_count > 255) ? 255 : win_count;
            exp_min   = mn;
            exp_last  = last_isi_m;
            exp_peak  = win_peak;
            pos = 0;
            model_clear_window();
        end else if (accept) begin
            exp_valid = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("valid", out_valid, exp_valid);
        chk("count", out_count, exp_count);
        chk("min_isi", out_min_isi, exp_min);
        chk("last_isi", out_last_isi, exp_last);
        chk("peak", out_peak, exp_peak);
        chk("overrun", overrun, exp_overrun);
    endtask

    task automatic drive(input bit e, input bit s, input logic [7:0] st);
        ena = e; spike = s; state = st;
        step();
    endtask

    task automatic do_reset();
        rst = 1; ena = 1; spike = 0; state = 0;
        step();
        rst = 0;
    endtask

    initial begin
        rst = 1; ena = 0; spike = 0; state = 0; out_ready = 1;
        do_reset();
        chk("reset_min_isi", out_min_isi, 8'hFF);

        // 1: quiet window with constant membrane value
        for (int c = 0; c < WIN; c++) drive(1, 0, 8'h20);
        chk("t1_valid", out_valid, 1);
        chk("t1_count", out_count, 0);
        chk("t1_min", out_min_isi, 8'hFF);
        chk("t1_last", out_last_isi, 0);
        chk("t1_peak", out_peak, 8'h20);

        // 2: pulses at 2, 5, 11
        do_reset();
        for (int c = 0; c < WIN; c++) drive(1, (c == 2 || c == 5 || c == 11), 8'h10);
        chk("t2_count", out_count, 3);
        chk("t2_min", out_min_isi, 3);
        chk("t2_last", out_last_isi, 6);

        // 3: held spike counts once, peak at cycle 7
        do_reset();
        for (int c = 0; c < WIN; c++)
            drive(1, (c >= 3 && c <= 8), (c == 7) ? 8'hC8 : (c < 7 ? 8'(c * 16) : 8'h40));
        chk("t3_count", out_count, 1);
        chk("t3_peak", out_peak, 8'hC8);

        // 4: interval spanning a window boundary
        do_reset();
        for (int c = 0; c < 2 * WIN; c++) begin
            drive(1, (c == 14 || c == 20), 8'h05);
            if (c == WIN - 1) chk("t4_w0_min", out_min_isi, 8'hFF);
        end
        chk("t4_count", out_count, 1);
        chk("t4_min", out_min_isi, 6);
        chk("t4_last", out_last_isi, 6);

        // 5: overwrite without acceptance, then accept
        do_reset();
        out_ready = 0;
        for (int c = 0; c < 2 * WIN; c++) drive(1, (c % 7 == 1), 8'(c));
        chk("t5_overrun", overrun, 1);
        chk("t5_valid", out_valid, 1);
        out_ready = 1;
        drive(0, 0, 8'h00);
        chk("t5_accept", out_valid, 0);
        for (int c = 0; c < 4; c++) drive(1, 0, 8'h00);
        chk("t5_sticky", overrun, 1);
        do_reset();
        chk("t5_rst_clears", overrun, 0);

        // 6: ena low extends the window; spikes during ena=0 are ignored
        for (int c = 0; c < 5; c++) drive(1, (c == 2), 8'h11);
        for (int c = 0; c < 10; c++) drive(0, c[0], 8'hF0);
        for (int c = 0; c < 10; c++) drive(1, 0, 8'h12);
        chk("t6_not_yet", out_valid, 0);
        drive(1, 0, 8'h12);
        chk("t6_closed", out_valid, 1);
        chk("t6_count", out_count, 1);
        chk("t6_peak", out_peak, 8'h12);

        // 6b: reset mid-window discards the partial window
        do_reset();
        for (int c = 0; c < 9; c++) drive(1, (c == 1 || c == 4), 8'h99);
        do_reset();
        for (int c = 0; c < WIN; c++) drive(1, (c == 3), 8'h10);
        chk("t6b_count", out_count, 1);
        chk("t6b_peak", out_peak, 8'h10);
        chk("t6b_last", out_last_isi, 0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 599) == 0);
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 3), 8'($urandom));
            rst = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spike_rate_monitor.md
Name: spike_rate_monitor

Overview:
- Downstream consumer of the current-based LIF neuron: samples its `spike` output and 8-bit membrane `state` each cycle.
- Reduces each fixed window to a summary record:
  - spike count
  - minimum inter-spike interval (ISI)
  - most recent ISI
  - peak membrane value
- Presents the record on a valid/ready interface for the readout/IO mux stage.

Parameters:
- WINDOW_LOG2, 8, window length = 2^WINDOW_LOG2 cycles.
- CNT_W, 8, spike-count width; count saturates.
- ISI_W, 8, ISI width; ISI values saturate at 2^ISI_W-1.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- ena  input  1  advance enable; when 0, all window, ISI and accumulator state holds.
- spike  input  1  neuron spike output.
- state  input  8  neuron membrane value (unsigned).
- out_valid  output  1  summary record available.
- out_ready  input  1  consumer accepts record when out_valid && out_ready.
- out_count  output  CNT_W  spike events in window.
- out_min_isi  output  ISI_W  smallest ISI completed in window; all-ones if none.
- out_last_isi  output  ISI_W  most recent ISI completed (may span windows); 0 until first ISI.
- out_peak  output  8  max `state` sampled in window.
- overrun  output  1  sticky; a record was overwritten before acceptance.

Behaviour:
- Reset (rst=1 at edge), all registers cleared:
  - win_cnt=0, spike_q=0, isi_timer=0, seen_first=0
  - acc_count=0, acc_min=all-ones, acc_peak=0
  - all outputs 0 except out_min_isi=all-ones
  - reset mid-window discards partial window; no record is emitted.
- Spike event: spike=1 && spike_q=0 (rising edge). spike_q <= spike every ena cycle.
  - A spike held high for N cycles counts once.
- Window:
  - win_cnt increments mod 2^WINDOW_LOG2 each ena cycle.
  - Last cycle is win_cnt = all-ones.
  - Events and state samples in that last cycle are included in its record.
- Count: acc_count += 1 per event; saturates at 2^CNT_W-1.
- Peak: acc_peak <= max(acc_peak, state) each ena cycle.
- ISI:
  - isi_timer increments each ena cycle, saturating at all-ones; it is not cleared at window boundaries.
  - On an event with seen_first=1: ISI = isi_timer + 1 (saturated). Update last_isi = ISI and acc_min = min(acc_min, ISI).
  - On every event: isi_timer <= 0, seen_first <= 1.
  - Events at cycles t0 and t1 give ISI = t1 - t0.
- Window close (ena && win_cnt all-ones):
  - Output regs load the final accumulator values, including this cycle's contribution.
  - out_valid <= 1.
  - Next cycle: acc_count=0, acc_min=all-ones, acc_peak=0; last_isi and isi_timer persist.
- Output FSM (2 states):
  - EMPTY: out_valid=0.
    - Window close -> FULL.
  - FULL: out_valid=1; data stable while out_ready=0.
    - out_ready=1 and no close -> EMPTY.
    - out_ready=1 and close in the same cycle -> stay FULL with the new record; no overrun.
    - out_ready=0 and close -> overwrite record, stay FULL, overrun <= 1.
- overrun clears only on rst.
- Handshake is independent of ena: acceptance works while ena=0.
- Latency: record visible on out_* the cycle after the closing cycle.
- Arithmetic:
  - All comparisons unsigned.
  - Saturation via compare-to-max before increment; no wrap on any counter except win_cnt.

Decomposition:
- Package spike_mon_pkg holds:
  - MEM_W=8
  - default widths
  - typedef of the summary record struct (count, min_isi, last_isi, peak)
  - output FSM enum {EMPTY, FULL}
- One natural sub-module: isi_tracker (edge detect, isi_timer, seen_first, last_isi, ISI output with event strobe).
- The window/accumulator/handshake logic stays in the top.

Test Plan (bench uses WINDOW_LOG2=4, i.e. 16-cycle windows; out_ready=1 unless stated):
1. Reset, no spikes, state=0x20 constant -> one cycle after closing cycle 15:
   - out_valid=1, out_count=0, out_min_isi=0xFF, out_last_isi=0, out_peak=0x20.
2. Spike 1-cycle pulses at cycles 2, 5, 11 in window 0 -> out_count=3, out_min_isi=3, out_last_isi=6.
3. Spike held high cycles 3–8; state ramps to 0xC8 at cycle 7 then falls -> out_count=1, out_peak=0xC8.
4. Spikes at cycle 14 (window 0) and cycle 20 (window 1):
   - window 1 record: out_count=1, out_min_isi=6, out_last_isi=6.
   - window 0 record: out_min_isi=0xFF.
5. out_ready=0 across two window closes -> second record overwrites the first and overrun=1.
   - Then out_ready=1 for one cycle -> out_valid=0.
   - overrun stays 1 until rst.
6. ena=0 for 10 cycles mid-window with spike toggling -> no counts change and the window extends by 10 cycles.
   - Also: rst asserted at cycle 9 of a window -> no record emitted, next record reflects only post-reset cycles.
